// File: rtl/commit_ctrl.sv
// rtl/commit_ctrl.sv - in-order ROB head commit sequencer (retire, store release, flush, halt)
module commit_ctrl #(
    parameter int ROB_BIT = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               head_valid,
    input  logic               head_ready,
    input  logic [1:0]         head_type,
    input  logic [4:0]         head_rd,
    input  logic [31:0]        head_value,
    input  logic [ROB_BIT-1:0] head_entry,
    input  logic               head_mispredict,
    input  logic [31:0]        head_target,
    output logic               commit_pop,
    output logic               rob_commit,
    output logic [4:0]         commit_reg_id,
    output logic [31:0]        commit_reg_data,
    output logic [ROB_BIT-1:0] commit_rob_entry,
    output logic               store_go,
    input  logic               store_done,
    output logic               rob_clear_up,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic               halted,
    output logic [31:0]        commit_count
);

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_WAIT_STORE = 2'd1;
    localparam logic [1:0] ST_FLUSH      = 2'd2;
    localparam logic [1:0] ST_HALT       = 2'd3;

    localparam logic [1:0] TYPE_REG    = 2'd0;
    localparam logic [1:0] TYPE_STORE  = 2'd1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] commit_count_q, commit_count_d;
    logic        fire;

    assign fire = rdy_in && (state_q == ST_RUN) && head_valid && head_ready;

    always_comb begin
        state_d          = state_q;
        redirect_pc_d    = redirect_pc_q;
        commit_pop       = 1'b0;
        rob_commit       = 1'b0;
        store_go         = 1'b0;
        rob_clear_up     = 1'b0;
        redirect_valid   = 1'b0;
        commit_reg_id    = head_rd;
        commit_reg_data  = head_value;
        commit_rob_entry = head_entry;

        case (state_q)
            ST_RUN: begin
                if (fire) begin
                    case (head_type)
                        TYPE_REG: begin
                            commit_pop = 1'b1;
                            rob_commit = (head_rd != 5'd0);
                        end
                        TYPE_STORE: begin
                            // Store is popped only once the LSB confirms the memory write
                            store_go = 1'b1;
                            state_d  = ST_WAIT_STORE;
                        end
                        TYPE_BRANCH: begin
                            commit_pop = 1'b1;
                            rob_commit = (head_rd != 5'd0);
                            if (head_mispredict) begin
                                redirect_pc_d = head_target;
                                state_d       = ST_FLUSH;
                            end
                        end
                        default: begin
                            commit_pop = 1'b1;
                            state_d    = ST_HALT;
                        end
                    endcase
                end
            end
            ST_WAIT_STORE: begin
                if (rdy_in && store_done) begin
                    commit_pop = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (rdy_in) begin
                    rob_clear_up   = 1'b1;
                    redirect_valid = 1'b1;
                    state_d        = ST_RUN;
                end
            end
            default: begin
            end
        endcase

        commit_count_d = commit_count_q + {31'd0, commit_pop};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= ST_RUN;
            redirect_pc_q  <= 32'd0;
            commit_count_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            redirect_pc_q  <= redirect_pc_d;
            commit_count_q <= commit_count_d;
        end
    end

    assign redirect_pc  = redirect_pc_q;
    assign halted       = (state_q == ST_HALT);
    assign commit_count = commit_count_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// tb/tb_commit_ctrl.sv - table-driven cycle-by-cycle bench for commit_ctrl
module tb_commit_ctrl;

    localparam int ROB_BIT = 4;

    logic               clk_in = 1'b0;
    logic               rst_in, rdy_in, head_valid, head_ready, head_mispredict, store_done;
    logic [1:0]         head_type;
    logic [4:0]         head_rd;
    logic [31:0]        head_value, head_target;
    logic [ROB_BIT-1:0] head_entry;
    logic               commit_pop, rob_commit, store_go, rob_clear_up, redirect_valid, halted;
    logic [4:0]         commit_reg_id;
    logic [31:0]        commit_reg_data, redirect_pc, commit_count;
    logic [ROB_BIT-1:0] commit_rob_entry;

    commit_ctrl #(.ROB_BIT(ROB_BIT)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .head_valid(head_valid), .head_ready(head_ready), .head_type(head_type),
        .head_rd(head_rd), .head_value(head_value), .head_entry(head_entry),
        .head_mispredict(head_mispredict), .head_target(head_target),
        .commit_pop(commit_pop), .rob_commit(rob_commit), .commit_reg_id(commit_reg_id),
        .commit_reg_data(commit_reg_data), .commit_rob_entry(commit_rob_entry),
        .store_go(store_go), .store_done(store_done), .rob_clear_up(rob_clear_up),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .commit_count(commit_count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rst, rdy, hv, hr;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] val, tgt;
        logic        mis, sd;
        logic        e_pop, e_rc, e_sg, e_clr, e_rv, e_halt;
        logic [31:0] e_rpc, e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [1:0] REG = 2'd0, ST = 2'd1, BR = 2'd2, EX = 2'd3;

    task automatic add(input logic rst, rdy, hv, hr, input logic [1:0] typ, input logic [4:0] rd,
                       input logic [31:0] val, tgt, input logic mis, sd,
                       input logic pop, rc, sg, clr, rv, hlt, input logic [31:0] rpc, cnt);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.hv = hv; v.hr = hr; v.typ = typ; v.rd = rd;
        v.val = val; v.tgt = tgt; v.mis = mis; v.sd = sd;
        v.e_pop = pop; v.e_rc = rc; v.e_sg = sg; v.e_clr = clr; v.e_rv = rv; v.e_halt = hlt;
        v.e_rpc = rpc; v.e_cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    initial begin
        //   rst rdy hv hr typ rd  val       tgt       mis sd   pop rc sg clr rv hlt rpc       cnt
        add(0, 1, 0, 0, REG, 0, 32'h0,    32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h0,   0);  // 0 reset state
        add(0, 1, 1, 1, REG, 5, 32'h11,   32'h0,    0, 0,   1, 1, 0, 0, 0, 0, 32'h0,   0);  // 1 REG stream
        add(0, 1, 1, 1, REG, 6, 32'h22,   32'h0,    0, 0,   1, 1, 0, 0, 0, 0, 32'h0,   1);
        add(0, 1, 1, 1, REG, 0, 32'h33,   32'h0,    0, 0,   1, 0, 0, 0, 0, 0, 32'h0,   2);
        add(0, 1, 0, 0, REG, 0, 32'h0,    32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h0,   3);  // 4
        add(0, 1, 1, 0, REG, 7, 32'h44,   32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h0,   3);  // 5 not ready
        add(0, 1, 1, 1, ST,  0, 32'h0,    32'h0,    0, 0,   0, 0, 1, 0, 0, 0, 32'h0,   3);  // 6 store_go
        add(0, 1, 1, 1, ST,  0, 32'h0,    32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h0,   3);
        add(0, 1, 1, 1, ST,  0, 32'h0,    32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h0,   3);
        add(0, 1, 1, 1, ST,  0, 32'h0,    32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h0,   3);
        add(0, 1, 1, 1, ST,  0, 32'h0,    32'h0,    0, 1,   1, 0, 0, 0, 0, 0, 32'h0,   3);  // 10 done
        add(0, 1, 0, 0, REG, 0, 32'h0,    32'h0,    0, 1,   0, 0, 0, 0, 0, 0, 32'h0,   4);  // 11 stray done
        add(0, 1, 1, 1, BR,  1, 32'h104,  32'h200,  1, 0,   1, 1, 0, 0, 0, 0, 32'h0,   4);  // 12 mispredict
        add(0, 1, 1, 1, REG, 7, 32'h77,   32'h0,    0, 0,   0, 0, 0, 1, 1, 0, 32'h200, 5);  // 13 flush
        add(0, 1, 1, 1, REG, 7, 32'h77,   32'h0,    0, 0,   1, 1, 0, 0, 0, 0, 32'h200, 5);  // 14 RUN again
        add(0, 1, 1, 1, BR,  0, 32'h50,   32'h300,  1, 0,   1, 0, 0, 0, 0, 0, 32'h200, 6);  // 15 x0 branch
        add(0, 0, 1, 1, REG, 8, 32'h88,   32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h300, 7);  // 16 stalled flush
        add(0, 0, 1, 1, REG, 8, 32'h88,   32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h300, 7);
        add(0, 0, 1, 1, REG, 8, 32'h88,   32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h300, 7);
        add(0, 1, 0, 0, REG, 0, 32'h0,    32'h0,    0, 0,   0, 0, 0, 1, 1, 0, 32'h300, 7);  // 19 flush fires
        add(0, 1, 0, 0, REG, 0, 32'h0,    32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h300, 7);
        add(0, 1, 1, 1, BR,  2, 32'h8,    32'h500,  0, 0,   1, 1, 0, 0, 0, 0, 32'h300, 7);  // 21 good branch
        add(0, 0, 1, 1, REG, 3, 32'h9,    32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h300, 8);  // 22 paused
        add(0, 1, 1, 1, REG, 3, 32'h9,    32'h0,    0, 0,   1, 1, 0, 0, 0, 0, 32'h300, 8);
        add(0, 1, 1, 1, ST,  0, 32'h0,    32'h0,    0, 1,   0, 0, 1, 0, 0, 0, 32'h300, 9);  // 24 same-cycle done
        add(0, 0, 1, 1, ST,  0, 32'h0,    32'h0,    0, 1,   0, 0, 0, 0, 0, 0, 32'h300, 9);
        add(0, 1, 1, 1, ST,  0, 32'h0,    32'h0,    0, 1,   1, 0, 0, 0, 0, 0, 32'h300, 9);
        add(0, 1, 1, 1, EX,  4, 32'h0,    32'h0,    0, 0,   1, 0, 0, 0, 0, 0, 32'h300, 10); // 27 EXIT
        add(0, 1, 1, 1, REG, 5, 32'h55,   32'h0,    0, 0,   0, 0, 0, 0, 0, 1, 32'h300, 11);
        add(0, 1, 1, 1, ST,  0, 32'h0,    32'h0,    0, 1,   0, 0, 0, 0, 0, 1, 32'h300, 11);
        add(1, 1, 0, 0, REG, 0, 32'h0,    32'h0,    0, 0,   0, 0, 0, 0, 0, 1, 32'h300, 11); // 30 reset
        add(0, 1, 0, 0, REG, 0, 32'h0,    32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h0,   0);
        add(0, 1, 1, 1, ST,  0, 32'h0,    32'h0,    0, 0,   0, 0, 1, 0, 0, 0, 32'h0,   0);  // 32
        add(0, 1, 1, 1, ST,  0, 32'h0,    32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h0,   0);
        add(1, 1, 0, 0, REG, 0, 32'h0,    32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h0,   0);  // 34 reset in wait
        add(0, 1, 0, 0, REG, 0, 32'h0,    32'h0,    0, 1,   0, 0, 0, 0, 0, 0, 32'h0,   0);  // late done
        add(0, 1, 0, 0, REG, 0, 32'h0,    32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h0,   0);
        add(0, 1, 1, 1, BR,  1, 32'h1,    32'h400,  1, 0,   1, 1, 0, 0, 0, 0, 32'h0,   0);  // 37
        add(1, 0, 0, 0, REG, 0, 32'h0,    32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h400, 1);  // reset in flush
        add(0, 1, 0, 0, REG, 0, 32'h0,    32'h0,    0, 0,   0, 0, 0, 0, 0, 0, 32'h0,   0);

        rst_in = 1'b1; rdy_in = 1'b1; head_valid = 1'b0; head_ready = 1'b0; head_type = REG;
        head_rd = 5'd0; head_value = 32'd0; head_entry = '0; head_mispredict = 1'b0;
        head_target = 32'd0; store_done = 1'b0;
        repeat (2) @(posedge clk_in);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk_in);
            #1;
            rst_in = vecs[i].rst; rdy_in = vecs[i].rdy; head_valid = vecs[i].hv;
            head_ready = vecs[i].hr; head_type = vecs[i].typ; head_rd = vecs[i].rd;
            head_value = vecs[i].val; head_target = vecs[i].tgt; head_mispredict = vecs[i].mis;
            store_done = vecs[i].sd; head_entry = ROB_BIT'(i);
            @(negedge clk_in);
            chk("commit_pop",     i, {31'd0, commit_pop},     {31'd0, vecs[i].e_pop});
            chk("rob_commit",     i, {31'd0, rob_commit},     {31'd0, vecs[i].e_rc});
            chk("store_go",       i, {31'd0, store_go},       {31'd0, vecs[i].e_sg});
            chk("rob_clear_up",   i, {31'd0, rob_clear_up},   {31'd0, vecs[i].e_clr});
            chk("redirect_valid", i, {31'd0, redirect_valid}, {31'd0, vecs[i].e_rv});
            chk("halted",         i, {31'd0, halted},         {31'd0, vecs[i].e_halt});
            chk("redirect_pc",    i, redirect_pc,             vecs[i].e_rpc);
            chk("commit_count",   i, commit_count,            vecs[i].e_cnt);
            if (vecs[i].e_rc) begin
                chk("commit_reg_id",    i, {27'd0, commit_reg_id},          {27'd0, vecs[i].rd});
                chk("commit_reg_data",  i, commit_reg_data,                 vecs[i].val);
                chk("commit_rob_entry", i, {28'd0, commit_rob_entry},       i & 32'hf);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/commit_ctrl.md
# commit_ctrl

In-order commit sequencer between the reorder buffer head and the architectural register file. Each cycle it inspects the ROB head and decides to retire it, stall it, or trigger a flush. Retirement means a register write-back, a store release handshake with the load/store buffer, a misprediction flush with PC redirect, or a halt. It is the only driver of the register file's `rob_commit` and `rob_clear_up` inputs.

## Interface

Parameters:
- `ROB_BIT`, default 4: ROB index width.

Ports:
- `clk_in` input 1: system clock, single clock domain.
- `rst_in` input 1: reset, synchronous, active-high.
- `rdy_in` input 1: pause when low. All state is frozen and all pulse outputs are 0.
- `head_valid` input 1: ROB non-empty.
- `head_ready` input 1: head result available.
- `head_type` input 2: head kind. 0 = REG, 1 = STORE, 2 = BRANCH, 3 = EXIT.
- `head_rd` input 5: destination register.
- `head_value` input 32: result or link value.
- `head_entry` input ROB_BIT: head ROB index.
- `head_mispredict` input 1: BRANCH only. Predicted direction or target was wrong.
- `head_target` input 32: correct next PC for BRANCH.
- `commit_pop` output 1: dequeue the ROB head this cycle.
- `rob_commit` output 1: register file write strobe.
- `commit_reg_id` output 5: register file write index.
- `commit_reg_data` output 32: register file write data.
- `commit_rob_entry` output ROB_BIT: ROB index being committed.
- `store_go` output 1: one-cycle release of the head store to the LSB.
- `store_done` input 1: LSB reports the released store has written memory.
- `rob_clear_up` output 1: one-cycle global flush (ROB, RS, LSB, register file rename state).
- `redirect_valid` output 1: fetch PC redirect strobe.
- `redirect_pc` output 32: redirect target.
- `halted` output 1: EXIT retired. Sticky.
- `commit_count` output 32: number of retired instructions.

## Operation

- FSM states: RUN, WAIT_STORE, FLUSH, HALT. Reset state is RUN.
- Define `fire = rdy_in && state==RUN && head_valid && head_ready`.
- Commit outputs are combinational from the current state and the head. State, counter, and latches are registered.
- REG on `fire`:
  - `commit_pop=1`.
  - `rob_commit = (head_rd != 0)`.
  - `commit_reg_id = head_rd`, `commit_reg_data = head_value`, `commit_rob_entry = head_entry`.
  - State stays RUN.
- STORE on `fire`:
  - `store_go=1` and `commit_pop=0`. Go to WAIT_STORE.
  - In WAIT_STORE with `rdy_in && store_done`: `commit_pop=1`, return to RUN.
  - `store_go` is never reasserted while in WAIT_STORE.
- BRANCH on `fire`:
  - Register write behaves as REG (link value, x0 suppressed). `commit_pop=1`.
  - If `head_mispredict`: latch `head_target` into `redirect_pc`, go to FLUSH.
  - Otherwise stay in RUN.
- FLUSH, one cycle, requires `rdy_in`:
  - `rob_clear_up=1`, `redirect_valid=1`, `redirect_pc` = latched target.
  - No commit or pop. Next state is RUN.
- EXIT on `fire`: `commit_pop=1`, no register write, go to HALT.
- HALT: `halted=1`. All strobes are 0 forever until reset.
- `commit_rob_entry`, `commit_reg_id`, and `commit_reg_data` show the head values whenever `rob_commit=0`. They carry no meaning in that case.
- `commit_count` increments by 1 on every cycle with `commit_pop=1`. It wraps modulo 2^32.
- `store_done` arriving in any state other than WAIT_STORE is ignored.
- Head not valid, or valid but not ready: no action. Remain in RUN.

## Timing

- Reset values:
  - State RUN.
  - `commit_count=0`, `halted=0`, `redirect_pc=0`.
  - `commit_pop`, `rob_commit`, `store_go`, `rob_clear_up`, `redirect_valid` all 0.
- Throughput: one REG or non-mispredicted BRANCH retirement per cycle, back-to-back. Zero-cycle latency from head ready to `rob_commit`.
- The register file captures `rob_commit` at the same edge where the ROB pops.
- Mispredict cost:
  - Commit cycle at edge N.
  - `rob_clear_up` and `redirect_valid` during cycle N+1.
  - RUN resumes at N+2.
- Store latency is 1 cycle (`store_go`) plus LSB latency. Pop occurs in the cycle `store_done` is seen. A `store_done` in the same cycle as `store_go` is not accepted.
- `rdy_in` low in any state:
  - No transition, no strobe, counter held.
  - FLUSH stays pending until `rdy_in` returns.
- Reset mid-WAIT_STORE or mid-FLUSH returns to RUN immediately. The pending flush is dropped.
- Reset clears HALT.

## Test plan

- REG stream: heads with rd=5/val=0x11, rd=6/val=0x22, rd=0/val=0x33, all ready, on consecutive cycles.
  - -> `rob_commit` = 1, 1, 0.
  - -> `commit_pop` = 1, 1, 1.
  - -> `commit_count` = 3.
- Store handshake: STORE head ready, `store_done` asserted 4 cycles after `store_go`.
  - -> `store_go` for exactly one cycle.
  - -> `commit_pop` only in the `store_done` cycle.
  - -> `commit_count` +1.
- Mispredict: BRANCH rd=1, value 0x104, target 0x200, mispredict=1.
  - -> commit cycle: `rob_commit` with reg 1 = 0x104.
  - -> next cycle: `rob_clear_up=1`, `redirect_valid=1`, `redirect_pc=0x200`.
  - -> following cycle: RUN accepts the head again.
- rdy_in stall: drop `rdy_in` during FLUSH for 3 cycles.
  - -> flush pulse is withheld, then appears for exactly 1 cycle after `rdy_in` returns.
- EXIT: EXIT head ready, followed by further ready REG heads.
  - -> `halted=1`, a single pop.
  - -> no further strobes until `rst_in`.
  - -> after reset, all outputs are 0.
- Reset in WAIT_STORE: assert `rst_in` while waiting for `store_done`.
  - -> state RUN, `commit_count=0`.
  - -> a late `store_done` produces no pop.
